icache_direct: RTL and testbench
================================

# icache_direct

Direct-mapped, read-only instruction cache between the core's instruction-fetch port and the instruction memory bus. It accepts one fetch at a time from the core's `icache_ena`/`icache_addr` request. On a hit it returns the word on `icache_data` with a one-cycle `icache_valid` pulse. On a miss it refills the whole line from memory with an in-order word burst, then responds.

## Interface
Parameters:
- `SETS`, 64: number of lines; power of two, at least 2.
- `LINE_WORDS`, 4: 32-bit words per line; power of two, at least 2.

Ports:
- `clk`  in  1  the single clock; everything is sampled on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `icache_ena`  in  1  fetch request; held by the core until `icache_valid`.
- `icache_addr`  in  32  fetch byte address; bits [1:0] ignored.
- `icache_valid`  out  1  one-cycle response strobe.
- `icache_data`  out  32  fetched instruction; meaningful only while `icache_valid`=1.
- `flush`  in  1  invalidate all lines (fence.i).
- `mem_req`  out  1  refill request; held high for the whole burst.
- `mem_addr`  out  32  line base address, low OFF+2 bits zero.
- `mem_valid`  in  1  one returned word per cycle while high.
- `mem_rdata`  in  32  returned word.
- `hit_cnt`  out  32  hit counter (see Configuration).
- `miss_cnt`  out  32  miss counter (see Configuration).

## Operation
Address split:
- OFF = log2(LINE_WORDS), IDX = log2(SETS).
- Word offset = addr[OFF+1:2]; index = addr[OFF+IDX+1:OFF+2]; tag = addr[31:OFF+IDX+2].

Storage:
- Per line: a valid bit, a tag and LINE_WORDS data words.
- Valid bits are flops; tag and data arrays may be synchronous-read RAM.

States: IDLE, LOOKUP, REFILL, RESP.
- IDLE: if `icache_ena`=1, latch the address into `req_addr`, issue the array read, go to LOOKUP.
- LOOKUP: compare the stored tag and valid bit against `req_addr`.
  - Hit: drive `icache_valid`=1 and the selected word; go to IDLE.
  - Miss: go to REFILL.
- REFILL:
  - `mem_req`=1, `mem_addr`={req_addr[31:OFF+2], zeros}.
  - Each `mem_valid` beat writes `mem_rdata` into data word `beat_cnt`, then increments `beat_cnt`.
  - The beat whose index equals the requested offset is also captured into `resp_word`.
  - After beat LINE_WORDS-1: write the tag, set the valid bit, drop `mem_req`, go to RESP.
- RESP: `icache_valid`=1, `icache_data`=`resp_word`; go to IDLE.

Handshake and boundary rules:
- `icache_ena` is ignored in every state except IDLE. The core's held request during the valid cycle is never re-accepted.
- `mem_valid` is ignored outside REFILL.
- Beats arrive strictly in order, from word 0 to word LINE_WORDS-1.
- `flush`:
  - In IDLE, LOOKUP or RESP: clears all valid bits at the next edge.
  - In LOOKUP, a flush does not affect that cycle's hit decision.
  - During REFILL: the burst still completes, but the line's valid bit is not set and the response is still delivered from `resp_word`. The refill is consumed once and never cached.
- `flush` in the same cycle as the final refill beat: the flush wins and the line stays invalid.
- Reset mid-refill: the burst is abandoned and `mem_req`=0 from the next cycle. The memory side shares `rst` and aborts too.
- Addresses that differ only in bits [1:0] map to the same word.

## Timing
- Reset values: state=IDLE, all valid bits 0, `icache_valid`=0, `icache_data`=0, `mem_req`=0, `mem_addr`=0, `beat_cnt`=0, counters 0.
- Hit: request sampled at edge N; `icache_valid` high in cycle N+1. One fetch every 2 cycles at best.
- Miss: `mem_req` rises in cycle N+2. With the first beat L cycles after `mem_req` rises and contiguous beats, `icache_valid` is high in cycle N+2+L+LINE_WORDS.
- `mem_valid` may stall between beats (gaps allowed); `mem_req` stays high across gaps.
- `icache_valid` is never high for two consecutive cycles.

## Configuration
- `ICACHE_PERF_EN` defined:
  - `hit_cnt` increments on each LOOKUP hit.
  - `miss_cnt` increments on each LOOKUP miss.
  - Both are 32-bit, wrap from 0xFFFFFFFF to 0, are cleared by `rst`, and are not cleared by `flush`.
- `ICACHE_PERF_EN` undefined: both ports are constant 0 and no counter flops are synthesized.

## Test plan
- Cold miss: after reset, fetch 0x00000104. Expect `mem_req` with `mem_addr`=0x00000100 and beats 0xA0,0xA1,0xA2,0xA3. Expect `icache_valid` with data 0xA1, LINE_WORDS+2+L cycles after acceptance.
- Hit after fill: then fetch 0x0000010C. Expect `icache_valid` one cycle after acceptance with data 0xA3 and `mem_req` staying 0. Fetching 0x0000010E returns the same word.
- Conflict eviction: with SETS=64 and LINE_WORDS=4, fetch 0x00000100, then 0x00000500 (same index), then 0x00000100. Expect three refills.
- Flush: fill a line, pulse `flush`, refetch the same address. Expect a refill. Assert `flush` during a refill: the response is still correct and the next same-line fetch misses again.
- Gapped burst and reset abort: insert 3-cycle gaps between beats; the response data is still correct. Assert `rst` after 2 beats: `mem_req` is 0 next cycle, and a refetch misses.
- With `ICACHE_PERF_EN`: the scenario-1 and scenario-2 sequence gives `hit_cnt`=2, `miss_cnt`=1. Without the macro, both counters read 0 throughout.

Source files
------------

// File: rtl/icache_direct.sv
// rtl/icache_direct.sv - direct-mapped read-only instruction cache; define ICACHE_PERF_EN for hit/miss counters
module icache_direct #(
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        icache_ena,
  input  logic [31:0] icache_addr,
  output logic        icache_valid,
  output logic [31:0] icache_data,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_valid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  localparam int OFF  = $clog2(LINE_WORDS);
  localparam int IDX  = $clog2(SETS);
  localparam int TAGW = 32 - OFF - IDX - 2;
  localparam logic [OFF-1:0] ONE_BEAT = 1;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    REFILL,
    RESP
  } state_t;

  state_t state_q;
  state_t state_d;

  // Valid bits are flops so flush and reset can clear every line at once.
  logic [SETS-1:0]  valid_q;
  logic [TAGW-1:0]  tag_mem [SETS];
  logic [31:0]      data_mem [SETS*LINE_WORDS];
  logic [TAGW-1:0]  tag_rd;
  logic [31:0]      data_rd;

  logic [31:0]      req_addr;
  logic [31:0]      resp_word;
  logic [OFF-1:0]   beat_cnt;
  logic             flush_pend;

  logic [IDX-1:0]   in_idx;
  logic [OFF-1:0]   in_off;
  logic [IDX-1:0]   req_idx;
  logic [OFF-1:0]   req_off;
  logic [TAGW-1:0]  req_tag;

  logic             hit;
  logic             accept;
  logic             beat_we;
  logic             fill_done;
  logic             set_valid;
  logic             unused_addr_bits;

  assign in_idx  = icache_addr[OFF+IDX+1:OFF+2];
  assign in_off  = icache_addr[OFF+1:2];
  assign req_idx = req_addr[OFF+IDX+1:OFF+2];
  assign req_off = req_addr[OFF+1:2];
  assign req_tag = req_addr[31:OFF+IDX+2];

  // Byte-select bits never matter for a word fetch.
  assign unused_addr_bits = ^req_addr[1:0];

  // The valid bit is read live in LOOKUP, so a flush there only lands at the next edge.
  assign hit = valid_q[req_idx] && (tag_rd == req_tag);

  // A flush seen at any point of the burst, including its last beat, keeps the line uncached.
  assign set_valid = fill_done && !flush_pend && !flush;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and all combinational outputs of the fetch/refill sequence.
  always_comb begin
    state_d      = state_q;
    icache_valid = 1'b0;
    icache_data  = '0;
    mem_req      = 1'b0;
    mem_addr     = '0;
    accept       = 1'b0;
    beat_we      = 1'b0;
    fill_done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (icache_ena) begin
          accept  = 1'b1;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          icache_valid = 1'b1;
          icache_data  = data_rd;
          state_d      = IDLE;
        end else begin
          state_d = REFILL;
        end
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {req_addr[31:OFF+2], {(OFF+2){1'b0}}};
        if (mem_valid) begin
          beat_we = 1'b1;
          if (&beat_cnt) begin
            fill_done = 1'b1;
            state_d   = RESP;
          end
        end
      end
      RESP: begin
        icache_valid = 1'b1;
        icache_data  = resp_word;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request address, burst beat counter, requested-word capture and mid-burst flush tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_addr   <= '0;
      resp_word  <= '0;
      beat_cnt   <= '0;
      flush_pend <= 1'b0;
    end else begin
      if (accept) begin
        req_addr <= icache_addr;
      end
      if (state_q == LOOKUP) begin
        beat_cnt   <= '0;
        flush_pend <= 1'b0;
      end
      if (beat_we) begin
        beat_cnt <= beat_cnt + ONE_BEAT;
        if (beat_cnt == req_off) begin
          resp_word <= mem_rdata;
        end
      end
      if ((state_q == REFILL) && flush) begin
        flush_pend <= 1'b1;
      end
    end
  end

  // Line valid bits: flush clears everything and takes priority over a completing fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (set_valid) begin
      valid_q[req_idx] <= 1'b1;
    end
  end

  // Tag and data arrays: synchronous read at acceptance, writes during refill.
  always_ff @(posedge clk) begin
    if (accept) begin
      tag_rd  <= tag_mem[in_idx];
      data_rd <= data_mem[{in_idx, in_off}];
    end
    if (beat_we) begin
      data_mem[{req_idx, beat_cnt}] <= mem_rdata;
    end
    if (fill_done) begin
      tag_mem[req_idx] <= req_tag;
    end
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  // Lookup outcome counters; they wrap and survive flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == LOOKUP) begin
      if (hit) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end else begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_icache_direct.sv
// tb/tb_icache_direct.sv - scoreboard bench for icache_direct with a latency/gap configurable memory model
module tb_icache_direct;

  logic        clk;
  logic        rst;
  logic        icache_ena;
  logic [31:0] icache_addr;
  logic        icache_valid;
  logic [31:0] icache_data;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic [31:0] mem_rdata;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  int          n_checks;
  int          n_fail;
  logic [31:0] exp_q[$];

  int          mem_lat;
  int          mem_gap;
  int          refill_cnt;
  logic [31:0] last_req_addr;

  icache_direct #(
    .SETS(64),
    .LINE_WORDS(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .icache_ena(icache_ena),
    .icache_addr(icache_addr),
    .icache_valid(icache_valid),
    .icache_data(icache_data),
    .flush(flush),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_valid(mem_valid),
    .mem_rdata(mem_rdata),
    .hit_cnt(hit_cnt),
    .miss_cnt(miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA0 + (a >> 2) - 32'h40;
  endfunction

  function automatic int miss_lat();
    return 2 + mem_lat + 4 + mem_gap * 3;
  endfunction

  // Memory model: first beat mem_lat cycles after mem_req rises, then mem_gap idle cycles between beats.
  initial begin
    int busy;
    int delay;
    int beat;
    busy = 0;
    delay = 0;
    beat = 0;
    mem_valid = 1'b0;
    mem_rdata = '0;
    refill_cnt = 0;
    last_req_addr = '0;
    forever begin
      @(negedge clk);
      if (rst || !mem_req) begin
        busy = 0;
        mem_valid = 1'b0;
      end else if (busy == 0) begin
        busy = 1;
        delay = mem_lat;
        beat = 0;
        mem_valid = 1'b0;
        refill_cnt++;
        last_req_addr = mem_addr;
      end else begin
        mem_valid = 1'b0;
        if (delay > 1) begin
          delay--;
        end else if (beat < 4) begin
          mem_valid = 1'b1;
          mem_rdata = mem_word(last_req_addr + 32'(beat * 4));
          beat++;
          delay = mem_gap + 1;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    rst = 1'b1;
    icache_ena = 1'b0;
    flush = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_flush();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] addr, input logic [31:0] exp_data, input bit exp_miss,
                       input int exp_lat, input int flush_at, input int rst_at, input string name);
    int          k;
    int          refills0;
    bit          seen;
    logic [31:0] exp;
    logic [31:0] got;
    refills0 = refill_cnt;
    @(negedge clk);
    icache_ena = 1'b1;
    icache_addr = addr;
    exp_q.push_back(exp_data);
    k = 0;
    seen = 0;
    while (!seen && k < 200) begin
      @(negedge clk);
      k++;
      flush = (k == flush_at);
      if (k == rst_at) begin
        rst = 1'b1;
        icache_ena = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (mem_req !== 1'b0) begin
          n_fail++;
          $display("FAIL %s reset_abort: mem_req got %b expected 0", name, mem_req);
        end
        void'(exp_q.pop_front());
        return;
      end
      if (icache_valid) seen = 1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s timeout: no icache_valid within %0d cycles", name, k);
      icache_ena = 1'b0;
      flush = 1'b0;
      exp_q.delete();
      return;
    end
    icache_ena = 1'b0;
    flush = 1'b0;
    got = icache_data;
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s data: got %h expected %h", name, got, exp);
    end
    n_checks++;
    if (k !== exp_lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d expected %0d", name, k, exp_lat);
    end
    n_checks++;
    if ((refill_cnt - refills0) !== (exp_miss ? 1 : 0)) begin
      n_fail++;
      $display("FAIL %s refills: got %0d expected %0d", name, refill_cnt - refills0, exp_miss ? 1 : 0);
    end
    if (exp_miss) begin
      n_checks++;
      if (last_req_addr !== {addr[31:4], 4'h0}) begin
        n_fail++;
        $display("FAIL %s mem_addr: got %h expected %h", name, last_req_addr, {addr[31:4], 4'h0});
      end
    end
    @(negedge clk);
    n_checks++;
    if (icache_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s valid_twice: got %b expected 0", name, icache_valid);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if (icache_valid !== 1'b0) begin n_fail++; $display("FAIL reset icache_valid: got %b expected 0", icache_valid); end
    n_checks++;
    if (icache_data !== 32'h0) begin n_fail++; $display("FAIL reset icache_data: got %h expected 0", icache_data); end
    n_checks++;
    if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset mem_req: got %b expected 0", mem_req); end
    n_checks++;
    if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset mem_addr: got %h expected 0", mem_addr); end
    n_checks++;
    if (hit_cnt !== 32'h0 || miss_cnt !== 32'h0) begin
      n_fail++;
      $display("FAIL reset counters: got %0d/%0d expected 0/0", hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_cold_miss();
    mem_lat = 1;
    mem_gap = 0;
    fetch(32'h0000_0104, 32'hA1, 1'b1, miss_lat(), 0, 0, "cold_miss");
  endtask

  task automatic test_hit();
    fetch(32'h0000_010C, 32'hA3, 1'b0, 1, 0, 0, "hit_word3");
    fetch(32'h0000_010E, 32'hA3, 1'b0, 1, 0, 0, "hit_byte_alias");
  endtask

  task automatic test_perf();
    logic [31:0] exp_hit;
    logic [31:0] exp_miss;
`ifdef ICACHE_PERF_EN
    exp_hit = 32'd2;
    exp_miss = 32'd1;
`else
    exp_hit = 32'd0;
    exp_miss = 32'd0;
`endif
    n_checks++;
    if (hit_cnt !== exp_hit) begin n_fail++; $display("FAIL perf hit_cnt: got %0d expected %0d", hit_cnt, exp_hit); end
    n_checks++;
    if (miss_cnt !== exp_miss) begin n_fail++; $display("FAIL perf miss_cnt: got %0d expected %0d", miss_cnt, exp_miss); end
  endtask

  task automatic test_conflict();
    int r0;
    do_reset();
    mem_lat = 2;
    mem_gap = 0;
    r0 = refill_cnt;
    fetch(32'h0000_0100, mem_word(32'h100), 1'b1, miss_lat(), 0, 0, "conflict_a");
    fetch(32'h0000_0500, mem_word(32'h500), 1'b1, miss_lat(), 0, 0, "conflict_b");
    fetch(32'h0000_0100, mem_word(32'h100), 1'b1, miss_lat(), 0, 0, "conflict_a_again");
    n_checks++;
    if (refill_cnt - r0 !== 3) begin
      n_fail++;
      $display("FAIL conflict refills: got %0d expected 3", refill_cnt - r0);
    end
  endtask

  task automatic test_flush();
    mem_lat = 1;
    mem_gap = 0;
    fetch(32'h0000_0108, 32'hA2, 1'b0, 1, 0, 0, "flush_prefill_hit");
    pulse_flush();
    fetch(32'h0000_0108, 32'hA2, 1'b1, miss_lat(), 0, 0, "flush_idle_refetch");
    fetch(32'h0000_0204, mem_word(32'h204), 1'b1, miss_lat(), 3, 0, "flush_mid_refill");
    fetch(32'h0000_0204, mem_word(32'h204), 1'b1, miss_lat(), 0, 0, "flush_mid_refetch");
    fetch(32'h0000_0304, mem_word(32'h304), 1'b1, miss_lat(), 6, 0, "flush_last_beat");
    fetch(32'h0000_0304, mem_word(32'h304), 1'b1, miss_lat(), 0, 0, "flush_last_refetch");
    fetch(32'h0000_0308, mem_word(32'h308), 1'b0, 1, 0, 0, "flush_after_refill_hit");
  endtask

  task automatic test_gapped_burst();
    mem_lat = 1;
    mem_gap = 3;
    fetch(32'h0000_0404, mem_word(32'h404), 1'b1, miss_lat(), 0, 0, "gapped_burst");
    mem_gap = 0;
  endtask

  task automatic test_back_to_back();
    fetch(32'h0000_0400, mem_word(32'h400), 1'b0, 1, 0, 0, "b2b_word0");
    fetch(32'h0000_040C, mem_word(32'h40C), 1'b0, 1, 0, 0, "b2b_word3");
  endtask

  task automatic test_reset_abort();
    mem_lat = 1;
    mem_gap = 0;
    fetch(32'h0000_0604, mem_word(32'h604), 1'b1, miss_lat(), 0, 5, "reset_abort");
    fetch(32'h0000_0604, mem_word(32'h604), 1'b1, miss_lat(), 0, 0, "reset_abort_refetch");
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    mem_lat = 1;
    mem_gap = 0;
    icache_addr = '0;
    do_reset();
    test_reset();
    test_cold_miss();
    test_hit();
    test_perf();
    test_conflict();
    test_flush();
    test_gapped_burst();
    test_back_to_back();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
